// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle MIPS control sequencer. Steps each instruction through
// fetch / decode / execute / memory / writeback over a shared ALU and a
// single unified memory port, stalling on mem_ready and counting retired
// instructions.
//
// Ports
//   clk, reset (async, active low)
//   OP, Function       : instruction opcode / funct fields from IR
//   mem_ready          : memory finishes the current access this cycle
//   PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
//   IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
//   ShamtSelector, ALUOp : datapath controls (decoded from state)
//   illegal_op         : registered one-cycle pulse for an unsupported opcode
//   instr_retired      : registered retired-instruction counter (wraps)
//   state_o            : current state, debug only
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RST      | held in reset, every output 0
// FETCH    | read IR from mem[PC], PC <= PC+4 once mem_ready
// DECODE   | ALUOut <= branch target, dispatch on OP
// EXEC_R   | R-type ALU operation (shamt feeds A for SLL/SRL)
// R_WB     | write ALUOut to rd
// EXEC_I   | immediate ALU operation (ADDI/ORI/LUI)
// I_WB     | write ALUOut to rt
// MEM_ADDR | effective address for LW/SW
// MEM_RD   | load access, waits on mem_ready
// LW_WB    | write MDR to rt
// MEM_WR   | store access, waits on mem_ready, retires on completion
// BRANCH   | compare rs/rt, conditional PC load from ALUOut
// JUMP     | PC <= jump target
// JAL      | PC <= jump target, $31 <= return address
module multicycle_control #(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OP,
  input  logic [5:0]         Function,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCondEQ,
  output logic               PCWriteCondNE,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic [1:0]         RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               ShamtSelector,
  output logic [2:0]         ALUOp,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instr_retired,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_R_WB     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_I_WB     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_LW_WB    = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_JAL      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;

  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_LUI  = 3'b110;
  localparam logic [2:0] ALU_FUNC = 3'b111;
  localparam logic [2:0] ALU_SUB  = 3'b001;

  state_t state, nextState;
  logic   retire;
  logic   illegalNext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RST;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_retired <= '0;
      illegal_op    <= 1'b0;
    end else begin
      illegal_op <= illegalNext;
      if (retire) begin
        instr_retired <= instr_retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    nextState     = state;
    retire        = 1'b0;
    illegalNext   = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCondEQ = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 2'b00;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    ShamtSelector = 1'b0;
    ALUOp         = 3'b000;

    unique case (state)
      S_RST: nextState = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        // IR and PC only load on the cycle the read actually completes.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) nextState = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALU_ADD;
        unique case (OP)
          OP_RTYPE:              nextState = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_LUI: nextState = S_EXEC_I;
          OP_LW, OP_SW:          nextState = S_MEM_ADDR;
          OP_BEQ, OP_BNE:        nextState = S_BRANCH;
          OP_J:                  nextState = S_JUMP;
          OP_JAL:                nextState = S_JAL;
          default: begin
            nextState   = S_FETCH;
            illegalNext = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA       = 1'b1;
        ALUOp         = ALU_FUNC;
        ShamtSelector = (Function == FN_SLL) || (Function == FN_SRL);
        nextState     = S_R_WB;
      end
      S_R_WB: begin
        RegDst    = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        nextState = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (OP == OP_ORI)      ALUOp = ALU_OR;
        else if (OP == OP_LUI) ALUOp = ALU_LUI;
        else                   ALUOp = ALU_ADD;
        nextState = S_I_WB;
      end
      S_I_WB: begin
        RegWrite  = 1'b1;
        retire    = 1'b1;
        nextState = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = ALU_ADD;
        nextState = (OP == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) nextState = S_LW_WB;
      end
      S_LW_WB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        nextState = S_FETCH;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          nextState = S_FETCH;
        end
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = ALU_SUB;
        PCSource      = 2'b01;
        PCWriteCondEQ = (OP == OP_BEQ);
        PCWriteCondNE = (OP == OP_BNE);
        retire        = 1'b1;
        nextState     = S_FETCH;
      end
      S_JUMP: begin
        PCSource  = 2'b10;
        PCWrite   = 1'b1;
        retire    = 1'b1;
        nextState = S_FETCH;
      end
      S_JAL: begin
        // Return address is the PC+4 already latched into PC during FETCH.
        PCSource  = 2'b10;
        PCWrite   = 1'b1;
        RegDst    = 2'b10;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        nextState = S_FETCH;
      end
      default: nextState = S_RST;
    endcase
  end

  assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the stimulus process drives one
// cycle of inputs and queues the hand-computed expected response for that
// cycle; a monitor pops and compares at every falling edge.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OP;
  logic [5:0]  Function;
  logic        mem_ready;
  logic        PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite;
  logic        IRWrite, MemtoReg, RegWrite, ALUSrcA, ShamtSelector, illegal_op;
  logic [1:0]  RegDst, ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic [31:0] instr_retired;
  logic [3:0]  state_o;

  multicycle_control #(.CNT_W(32), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Function(Function), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ShamtSelector(ShamtSelector),
    .ALUOp(ALUOp), .illegal_op(illegal_op), .instr_retired(instr_retired),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Control word layout, MSB first:
  // PCWrite CondEQ CondNE IorD MemRead MemWrite IRWrite MemtoReg
  // RegDst[1:0] RegWrite ALUSrcA ALUSrcB[1:0] PCSource[1:0] Shamt ALUOp[2:0]
  logic [19:0] actCtrl;
  assign actCtrl = {PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
                    IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                    ShamtSelector, ALUOp};

  localparam logic [19:0] B_PCW    = 20'h80000;
  localparam logic [19:0] B_EQ     = 20'h40000;
  localparam logic [19:0] B_NE     = 20'h20000;
  localparam logic [19:0] B_IORD   = 20'h10000;
  localparam logic [19:0] B_MRD    = 20'h08000;
  localparam logic [19:0] B_MWR    = 20'h04000;
  localparam logic [19:0] B_IRW    = 20'h02000;
  localparam logic [19:0] B_M2R    = 20'h01000;
  localparam logic [19:0] DST_RD   = 20'h00400;
  localparam logic [19:0] DST_31   = 20'h00800;
  localparam logic [19:0] B_RW     = 20'h00200;
  localparam logic [19:0] B_SRCA   = 20'h00100;
  localparam logic [19:0] SRCB_4   = 20'h00040;
  localparam logic [19:0] SRCB_IMM = 20'h00080;
  localparam logic [19:0] SRCB_BR  = 20'h000C0;
  localparam logic [19:0] PCS_OUT  = 20'h00010;
  localparam logic [19:0] PCS_J    = 20'h00020;
  localparam logic [19:0] B_SHAMT  = 20'h00008;
  localparam logic [19:0] A_ADD    = 20'h00004;
  localparam logic [19:0] A_OR     = 20'h00005;
  localparam logic [19:0] A_LUI    = 20'h00006;
  localparam logic [19:0] A_FUNC   = 20'h00007;
  localparam logic [19:0] A_SUB    = 20'h00001;

  localparam logic [19:0] C_NONE   = 20'h00000;
  localparam logic [19:0] C_FWAIT  = B_MRD | SRCB_4 | A_ADD;
  localparam logic [19:0] C_FETCH  = C_FWAIT | B_PCW | B_IRW;
  localparam logic [19:0] C_DEC    = SRCB_BR | A_ADD;
  localparam logic [19:0] C_EXR    = B_SRCA | A_FUNC;
  localparam logic [19:0] C_RWB    = DST_RD | B_RW;
  localparam logic [19:0] C_EXI    = B_SRCA | SRCB_IMM;
  localparam logic [19:0] C_IWB    = B_RW;
  localparam logic [19:0] C_MADDR  = B_SRCA | SRCB_IMM | A_ADD;
  localparam logic [19:0] C_MRD    = B_IORD | B_MRD;
  localparam logic [19:0] C_LWWB   = B_M2R | B_RW;
  localparam logic [19:0] C_MWR    = B_IORD | B_MWR;
  localparam logic [19:0] C_BR     = B_SRCA | PCS_OUT | A_SUB;
  localparam logic [19:0] C_JUMP   = B_PCW | PCS_J;
  localparam logic [19:0] C_JAL    = B_PCW | PCS_J | DST_31 | B_RW;

  localparam logic [3:0] RST = 4'd0, FET = 4'd1, DEC = 4'd2, EXR = 4'd3, RWB = 4'd4,
                         EXI = 4'd5, IWB = 4'd6, MAD = 4'd7, MRD = 4'd8, LWB = 4'd9,
                         MWR = 4'd10, BRA = 4'd11, JMP = 4'd12, JAL = 4'd13;

  typedef struct {
    logic [3:0]  st;
    logic [19:0] ctrl;
    logic [31:0] cnt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   nCmp = 0;
  int   nMis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nCmp++;
    if (act !== expv) begin
      nMis++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, expv);
    end
  endtask

  // Monitor: one expected response per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state_o", {28'h0, state_o}, {28'h0, e.st});
        chk("ctrl", {12'h0, actCtrl}, {12'h0, e.ctrl});
        chk("instr_retired", instr_retired, e.cnt);
        chk("illegal_op", {31'h0, illegal_op}, {31'h0, e.ill});
      end
    end
  end

  // Drive one cycle's inputs after the rising edge and queue its expectation.
  // midRst pulls reset low part-way through the cycle, away from any edge.
  task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic mr, input logic midRst, input logic [3:0] st,
                     input logic [19:0] ctrl, input int cnt, input logic ill);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; OP = op; Function = fn; mem_ready = mr;
    if (midRst) begin
      #2;
      reset = 1'b0;
    end
    e.st = st; e.ctrl = ctrl; e.cnt = 32'(cnt); e.ill = ill;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; OP = 6'h00; Function = 6'h00; mem_ready = 1'b1;
    // reset held with mem_ready high, then released
    cyc(0, 6'h00, 6'h00, 1, 0, RST, C_NONE, 0, 0);
    cyc(0, 6'h00, 6'h00, 1, 0, RST, C_NONE, 0, 0);
    cyc(0, 6'h00, 6'h00, 1, 0, RST, C_NONE, 0, 0);
    cyc(1, 6'h00, 6'h00, 1, 0, RST, C_NONE, 0, 0);
    // ADDI
    cyc(1, 6'h08, 6'h00, 1, 0, FET, C_FETCH, 0, 0);
    cyc(1, 6'h08, 6'h00, 1, 0, DEC, C_DEC, 0, 0);
    cyc(1, 6'h08, 6'h00, 1, 0, EXI, C_EXI | A_ADD, 0, 0);
    cyc(1, 6'h08, 6'h00, 1, 0, IWB, C_IWB, 0, 0);
    // SLL, with one fetch stall first
    cyc(1, 6'h00, 6'h00, 0, 0, FET, C_FWAIT, 1, 0);
    cyc(1, 6'h00, 6'h00, 1, 0, FET, C_FETCH, 1, 0);
    cyc(1, 6'h00, 6'h00, 1, 0, DEC, C_DEC, 1, 0);
    cyc(1, 6'h00, 6'h00, 1, 0, EXR, C_EXR | B_SHAMT, 1, 0);
    cyc(1, 6'h00, 6'h00, 1, 0, RWB, C_RWB, 1, 0);
    // ADD (funct 0x20): no shamt
    cyc(1, 6'h00, 6'h20, 1, 0, FET, C_FETCH, 2, 0);
    cyc(1, 6'h00, 6'h20, 1, 0, DEC, C_DEC, 2, 0);
    cyc(1, 6'h00, 6'h20, 1, 0, EXR, C_EXR, 2, 0);
    cyc(1, 6'h00, 6'h20, 1, 0, RWB, C_RWB, 2, 0);
    // SRL (funct 0x02), mem_ready low outside memory states is ignored
    cyc(1, 6'h00, 6'h02, 1, 0, FET, C_FETCH, 3, 0);
    cyc(1, 6'h00, 6'h02, 0, 0, DEC, C_DEC, 3, 0);
    cyc(1, 6'h00, 6'h02, 0, 0, EXR, C_EXR | B_SHAMT, 3, 0);
    cyc(1, 6'h00, 6'h02, 0, 0, RWB, C_RWB, 3, 0);
    // ORI, LUI
    cyc(1, 6'h0d, 6'h00, 1, 0, FET, C_FETCH, 4, 0);
    cyc(1, 6'h0d, 6'h00, 1, 0, DEC, C_DEC, 4, 0);
    cyc(1, 6'h0d, 6'h00, 1, 0, EXI, C_EXI | A_OR, 4, 0);
    cyc(1, 6'h0d, 6'h00, 1, 0, IWB, C_IWB, 4, 0);
    cyc(1, 6'h0f, 6'h00, 1, 0, FET, C_FETCH, 5, 0);
    cyc(1, 6'h0f, 6'h00, 1, 0, DEC, C_DEC, 5, 0);
    cyc(1, 6'h0f, 6'h00, 1, 0, EXI, C_EXI | A_LUI, 5, 0);
    cyc(1, 6'h0f, 6'h00, 1, 0, IWB, C_IWB, 5, 0);
    // LW with three stall cycles in MEM_RD: 8 cycles total
    cyc(1, 6'h23, 6'h00, 1, 0, FET, C_FETCH, 6, 0);
    cyc(1, 6'h23, 6'h00, 1, 0, DEC, C_DEC, 6, 0);
    cyc(1, 6'h23, 6'h00, 1, 0, MAD, C_MADDR, 6, 0);
    cyc(1, 6'h23, 6'h00, 0, 0, MRD, C_MRD, 6, 0);
    cyc(1, 6'h23, 6'h00, 0, 0, MRD, C_MRD, 6, 0);
    cyc(1, 6'h23, 6'h00, 0, 0, MRD, C_MRD, 6, 0);
    cyc(1, 6'h23, 6'h00, 1, 0, MRD, C_MRD, 6, 0);
    cyc(1, 6'h23, 6'h00, 1, 0, LWB, C_LWWB, 6, 0);
    // SW, no stall
    cyc(1, 6'h2b, 6'h00, 1, 0, FET, C_FETCH, 7, 0);
    cyc(1, 6'h2b, 6'h00, 1, 0, DEC, C_DEC, 7, 0);
    cyc(1, 6'h2b, 6'h00, 1, 0, MAD, C_MADDR, 7, 0);
    cyc(1, 6'h2b, 6'h00, 1, 0, MWR, C_MWR, 7, 0);
    // BNE, BEQ, J, JAL
    cyc(1, 6'h05, 6'h00, 1, 0, FET, C_FETCH, 8, 0);
    cyc(1, 6'h05, 6'h00, 1, 0, DEC, C_DEC, 8, 0);
    cyc(1, 6'h05, 6'h00, 1, 0, BRA, C_BR | B_NE, 8, 0);
    cyc(1, 6'h04, 6'h00, 1, 0, FET, C_FETCH, 9, 0);
    cyc(1, 6'h04, 6'h00, 1, 0, DEC, C_DEC, 9, 0);
    cyc(1, 6'h04, 6'h00, 1, 0, BRA, C_BR | B_EQ, 9, 0);
    cyc(1, 6'h02, 6'h00, 1, 0, FET, C_FETCH, 10, 0);
    cyc(1, 6'h02, 6'h00, 1, 0, DEC, C_DEC, 10, 0);
    cyc(1, 6'h02, 6'h00, 1, 0, JMP, C_JUMP, 10, 0);
    cyc(1, 6'h03, 6'h00, 1, 0, FET, C_FETCH, 11, 0);
    cyc(1, 6'h03, 6'h00, 1, 0, DEC, C_DEC, 11, 0);
    cyc(1, 6'h03, 6'h00, 1, 0, JAL, C_JAL, 11, 0);
    // illegal opcode: one-cycle pulse, back to FETCH, count unchanged
    cyc(1, 6'h3f, 6'h00, 1, 0, FET, C_FETCH, 12, 0);
    cyc(1, 6'h3f, 6'h00, 1, 0, DEC, C_DEC, 12, 0);
    cyc(1, 6'h3f, 6'h00, 0, 0, FET, C_FWAIT, 12, 1);
    cyc(1, 6'h3f, 6'h00, 0, 0, FET, C_FWAIT, 12, 0);
    // SW stalled, reset dropped mid-cycle during MEM_WR
    cyc(1, 6'h2b, 6'h00, 1, 0, FET, C_FETCH, 12, 0);
    cyc(1, 6'h2b, 6'h00, 1, 0, DEC, C_DEC, 12, 0);
    cyc(1, 6'h2b, 6'h00, 0, 0, MAD, C_MADDR, 12, 0);
    cyc(1, 6'h2b, 6'h00, 0, 0, MWR, C_MWR, 12, 0);
    cyc(1, 6'h2b, 6'h00, 0, 1, RST, C_NONE, 0, 0);
    cyc(0, 6'h2b, 6'h00, 1, 0, RST, C_NONE, 0, 0);
    cyc(1, 6'h2b, 6'h00, 1, 0, RST, C_NONE, 0, 0);
    // counting resumes from zero after reset
    cyc(1, 6'h2b, 6'h00, 1, 0, FET, C_FETCH, 0, 0);
    cyc(1, 6'h2b, 6'h00, 1, 0, DEC, C_DEC, 0, 0);
    cyc(1, 6'h2b, 6'h00, 1, 0, MAD, C_MADDR, 0, 0);
    cyc(1, 6'h2b, 6'h00, 1, 0, MWR, C_MWR, 0, 0);
    cyc(1, 6'h00, 6'h00, 0, 0, FET, C_FWAIT, 1, 0);

    repeat (2) @(negedge clk);
    #1;
    nCmp++;
    if (q.size() != 0) begin
      nMis++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
